// File: rtl/int_issue_queue_pkg.sv
// Shared widths, opcode encodings and the operand-slot record for the integer issue queue.
// Latency: n/a (types, constants and one combinational helper).
// Backpressure: n/a.
package int_issue_queue_pkg;

  localparam int TAG_W    = 6;   // physical register / ROB tag width
  localparam int DATA_W   = 32;  // operand and immediate width
  localparam int OPC_W    = 5;   // internal opcode width
  localparam int IQ_DEPTH = 4;   // default number of queue entries

  typedef enum logic [OPC_W-1:0] {
    OP_ADD = 5'd0,
    OP_SUB = 5'd1,
    OP_AND = 5'd2,
    OP_OR  = 5'd3,
    OP_XOR = 5'd4,
    OP_SLT = 5'd5,
    OP_SLL = 5'd6,
    OP_SRL = 5'd7
  } int_opcode_e;

  // One source operand: either a value (rdy=1) or the tag of its producer (rdy=0).
  typedef struct packed {
    logic              rdy;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } operand_t;

  // Applies a CDB broadcast to an operand that is still waiting on its producer.
  function automatic operand_t apply_wakeup(input operand_t          src,
                                            input logic              cdb_vld,
                                            input logic [TAG_W-1:0]  cdb_tag,
                                            input logic [DATA_W-1:0] cdb_dat);
    operand_t res;
    res = src;
    if (!src.rdy && cdb_vld && (src.tag == cdb_tag)) begin
      res.rdy  = 1'b1;
      res.data = cdb_dat;
    end
    return res;
  endfunction

endpackage

// File: rtl/int_issue_queue_if.sv
// Bundle of dispatch, CDB snoop and issue handshake signals around the integer issue queue.
// Latency: n/a (wiring only).
// Backpressure: issue_ready stalls issue; issueque_full_integer stalls dispatch.
// Ports: master = front end / CDB / execution unit side, slave = the issue queue.
interface int_issue_queue_if;
  import int_issue_queue_pkg::*;

  logic              dispatch_en_integer;
  logic [OPC_W-1:0]  dispatch_opcode;
  logic [TAG_W-1:0]  dispatch_rd_tag;
  logic [DATA_W-1:0] dispatch_rs1_data;
  logic [TAG_W-1:0]  dispatch_rs1_tag;
  logic              dispatch_rs1_valid;
  logic [DATA_W-1:0] dispatch_rs2_data;
  logic [TAG_W-1:0]  dispatch_rs2_tag;
  logic              dispatch_rs2_valid;
  logic [DATA_W-1:0] dispatch_imm;

  logic              CDB_valid;
  logic [TAG_W-1:0]  CDB_tag;
  logic [DATA_W-1:0] CDB_data;

  logic              issueque_full_integer;

  logic              issue_valid;
  logic              issue_ready;
  logic [OPC_W-1:0]  issue_opcode;
  logic [TAG_W-1:0]  issue_rd_tag;
  logic [DATA_W-1:0] issue_rs1_data;
  logic [DATA_W-1:0] issue_rs2_data;
  logic [DATA_W-1:0] issue_imm;

  modport master (
    output dispatch_en_integer, dispatch_opcode, dispatch_rd_tag,
           dispatch_rs1_data, dispatch_rs1_tag, dispatch_rs1_valid,
           dispatch_rs2_data, dispatch_rs2_tag, dispatch_rs2_valid, dispatch_imm,
           CDB_valid, CDB_tag, CDB_data, issue_ready,
    input  issueque_full_integer, issue_valid, issue_opcode, issue_rd_tag,
           issue_rs1_data, issue_rs2_data, issue_imm
  );

  modport slave (
    input  dispatch_en_integer, dispatch_opcode, dispatch_rd_tag,
           dispatch_rs1_data, dispatch_rs1_tag, dispatch_rs1_valid,
           dispatch_rs2_data, dispatch_rs2_tag, dispatch_rs2_valid, dispatch_imm,
           CDB_valid, CDB_tag, CDB_data, issue_ready,
    output issueque_full_integer, issue_valid, issue_opcode, issue_rd_tag,
           issue_rs1_data, issue_rs2_data, issue_imm
  );

endinterface

// File: rtl/int_issue_queue_iq_operand.sv
// One source-operand slot of an issue-queue entry: holds rdy/tag/data and snoops the CDB.
// Latency: a CDB match (on the held or the incoming value) shows as rdy=1 after one edge.
// Backpressure: none; wr_en selects a new value (dispatch or shift), otherwise the slot holds.
// Ports: clk, reset (async active-high), wr_en/wr_opnd load source, cdb_* snoop, opnd = registered state.
module iq_operand
  import int_issue_queue_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  operand_t          wr_opnd,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output operand_t          opnd
);

  operand_t opnd_q;
  operand_t opnd_d;
  operand_t src;

  // The wakeup is applied after the source mux, so a freshly dispatched operand gets the
  // same-cycle CDB bypass and an entry shifting down does not miss a broadcast. Slots of
  // invalid entries may also wake; that is harmless because they are rewritten before use.
  always_comb begin
    src    = wr_en ? wr_opnd : opnd_q;
    opnd_d = apply_wakeup(src, cdb_valid, cdb_tag, cdb_data);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opnd_q <= '0;
    end else begin
      opnd_q <= opnd_d;
    end
  end

  assign opnd = opnd_q;

endmodule

// File: rtl/int_issue_queue.sv
// Integer issue queue: collapsing, age-ordered (entry 0 oldest); issues the oldest op whose operands are ready.
// Latency: ready dispatch -> issue_valid next cycle; last-operand CDB wakeup -> issue_valid next cycle.
// Backpressure: issue_ready low holds the winner; dispatch is dropped when full unless an issue fires that cycle.
// Ports: clk, reset (async active-high), iq (slave modport: dispatch, CDB snoop, issue handshake, full flag).
module int_issue_queue
  import int_issue_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH  // 2..16
) (
  input logic              clk,
  input logic              reset,
  int_issue_queue_if.slave iq
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  wr_idx;
  logic [DEPTH-1:0]  valid_q, valid_d, valid_up;
  logic [DEPTH-1:0]  ready_vec;
  logic [DEPTH-1:0]  opnd_wr_en;

  logic [OPC_W-1:0]  opcode_q [DEPTH];
  logic [OPC_W-1:0]  opcode_d [DEPTH];
  logic [OPC_W-1:0]  opcode_up[DEPTH];
  logic [TAG_W-1:0]  rd_tag_q [DEPTH];
  logic [TAG_W-1:0]  rd_tag_d [DEPTH];
  logic [TAG_W-1:0]  rd_tag_up[DEPTH];
  logic [DATA_W-1:0] imm_q    [DEPTH];
  logic [DATA_W-1:0] imm_d    [DEPTH];
  logic [DATA_W-1:0] imm_up   [DEPTH];

  operand_t          rs1_q [DEPTH];
  operand_t          rs2_q [DEPTH];
  operand_t          rs1_up[DEPTH];
  operand_t          rs2_up[DEPTH];
  operand_t          rs1_wr[DEPTH];
  operand_t          rs2_wr[DEPTH];
  operand_t          disp_rs1, disp_rs2;

  logic [IDX_W-1:0]  win_idx;
  logic              issue_vld;
  logic              issue_fire;
  logic              full;
  logic              disp_accept;

  assign disp_rs1 = '{rdy: iq.dispatch_rs1_valid, tag: iq.dispatch_rs1_tag, data: iq.dispatch_rs1_data};
  assign disp_rs2 = '{rdy: iq.dispatch_rs2_valid, tag: iq.dispatch_rs2_tag, data: iq.dispatch_rs2_data};

  // Per-entry view of the neighbour above, used when the queue collapses over an issued entry.
  assign valid_up = {1'b0, valid_q[DEPTH-1:1]};

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    if (gi < DEPTH - 1) begin : g_up
      assign opcode_up[gi] = opcode_q[gi+1];
      assign rd_tag_up[gi] = rd_tag_q[gi+1];
      assign imm_up[gi]    = imm_q[gi+1];
      assign rs1_up[gi]    = rs1_q[gi+1];
      assign rs2_up[gi]    = rs2_q[gi+1];
    end else begin : g_top
      assign opcode_up[gi] = '0;
      assign rd_tag_up[gi] = '0;
      assign imm_up[gi]    = '0;
      assign rs1_up[gi]    = '0;
      assign rs2_up[gi]    = '0;
    end

    // Readiness comes from registered state only: a wakeup never issues in the same cycle.
    assign ready_vec[gi] = valid_q[gi] & rs1_q[gi].rdy & rs2_q[gi].rdy;

    iq_operand u_rs1 (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (opnd_wr_en[gi]),
      .wr_opnd   (rs1_wr[gi]),
      .cdb_valid (iq.CDB_valid),
      .cdb_tag   (iq.CDB_tag),
      .cdb_data  (iq.CDB_data),
      .opnd      (rs1_q[gi])
    );

    iq_operand u_rs2 (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (opnd_wr_en[gi]),
      .wr_opnd   (rs2_wr[gi]),
      .cdb_valid (iq.CDB_valid),
      .cdb_tag   (iq.CDB_tag),
      .cdb_data  (iq.CDB_data),
      .opnd      (rs2_q[gi])
    );
  end

  // Oldest-first select: scanning downward leaves the lowest ready index as winner.
  always_comb begin
    win_idx   = '0;
    issue_vld = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready_vec[i]) begin
        win_idx   = IDX_W'(i);
        issue_vld = 1'b1;
      end
    end
  end

  assign full        = (count_q == CNT_W'(DEPTH));
  assign issue_fire  = issue_vld & iq.issue_ready;
  // An issue in the same cycle frees a slot, so a full queue can still take that dispatch.
  assign disp_accept = iq.dispatch_en_integer & (~full | issue_fire);
  // The new op lands just above the surviving entries, one lower if the queue collapses.
  assign wr_idx      = issue_fire ? (count_q - CNT_W'(1)) : count_q;

  always_comb begin
    count_d    = count_q + CNT_W'(disp_accept) - CNT_W'(issue_fire);
    valid_d    = valid_q;
    opnd_wr_en = '0;
    for (int i = 0; i < DEPTH; i++) begin
      opcode_d[i] = opcode_q[i];
      rd_tag_d[i] = rd_tag_q[i];
      imm_d[i]    = imm_q[i];
      rs1_wr[i]   = rs1_up[i];
      rs2_wr[i]   = rs2_up[i];
      if (disp_accept && (wr_idx == CNT_W'(i))) begin
        valid_d[i]    = 1'b1;
        opcode_d[i]   = iq.dispatch_opcode;
        rd_tag_d[i]   = iq.dispatch_rd_tag;
        imm_d[i]      = iq.dispatch_imm;
        rs1_wr[i]     = disp_rs1;
        rs2_wr[i]     = disp_rs2;
        opnd_wr_en[i] = 1'b1;
      end else if (issue_fire && (IDX_W'(i) >= win_idx)) begin
        // Winner and everything above it move down one slot.
        valid_d[i]    = valid_up[i];
        opcode_d[i]   = opcode_up[i];
        rd_tag_d[i]   = rd_tag_up[i];
        imm_d[i]      = imm_up[i];
        opnd_wr_en[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        opcode_q[i] <= '0;
        rd_tag_q[i] <= '0;
        imm_q[i]    <= '0;
      end
    end else begin
      count_q <= count_d;
      valid_q <= valid_d;
      for (int i = 0; i < DEPTH; i++) begin
        opcode_q[i] <= opcode_d[i];
        rd_tag_q[i] <= rd_tag_d[i];
        imm_q[i]    <= imm_d[i];
      end
    end
  end

  assign iq.issueque_full_integer = full;
  assign iq.issue_valid           = issue_vld;
  assign iq.issue_opcode          = issue_vld ? opcode_q[win_idx]    : '0;
  assign iq.issue_rd_tag          = issue_vld ? rd_tag_q[win_idx]    : '0;
  assign iq.issue_rs1_data        = issue_vld ? rs1_q[win_idx].data  : '0;
  assign iq.issue_rs2_data        = issue_vld ? rs2_q[win_idx].data  : '0;
  assign iq.issue_imm             = issue_vld ? imm_q[win_idx]       : '0;

endmodule

// File: tb/tb_int_issue_queue.sv
// Self-checking bench for int_issue_queue: directed scenarios then random traffic vs an age-ordered list model.
// Latency: outputs compared 1 time unit after each rising edge.
// Backpressure: issue_ready driven directly (held low, high and randomised).
module tb_int_issue_queue;
  import int_issue_queue_pkg::*;

  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  int_issue_queue_if bus ();

  int_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .iq    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: list of waiting ops, oldest first.
  typedef struct packed {
    logic              r1;
    logic              r2;
    logic [TAG_W-1:0]  t1;
    logic [TAG_W-1:0]  t2;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    logic [OPC_W-1:0]  opc;
    logic [TAG_W-1:0]  rd;
    logic [DATA_W-1:0] imm;
  } ent_t;

  ent_t mq[$];

  function automatic int model_winner();
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].r1 && mq[i].r2) return i;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    int   w;
    ent_t e;
    w = model_winner();
    e = '0;
    if (w >= 0) e = mq[w];
    chk({tag, "_full"},  32'(bus.issueque_full_integer), 32'(mq.size() == DEPTH));
    chk({tag, "_vld"},   32'(bus.issue_valid),           32'(w >= 0));
    chk({tag, "_opc"},   32'(bus.issue_opcode),          32'(e.opc));
    chk({tag, "_rd"},    32'(bus.issue_rd_tag),          32'(e.rd));
    chk({tag, "_rs1"},   bus.issue_rs1_data,             e.d1);
    chk({tag, "_rs2"},   bus.issue_rs2_data,             e.d2);
    chk({tag, "_imm"},   bus.issue_imm,                  e.imm);
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int   w;
    bit   fire;
    bit   accept;
    bit   m1, m2;
    ent_t e;
    w      = model_winner();
    fire   = (w >= 0) && (bus.issue_ready === 1'b1);
    accept = (bus.dispatch_en_integer === 1'b1) && ((mq.size() < DEPTH) || fire);
    if (bus.CDB_valid) begin
      for (int i = 0; i < mq.size(); i++) begin
        e = mq[i];
        if (!e.r1 && e.t1 == bus.CDB_tag) begin e.r1 = 1'b1; e.d1 = bus.CDB_data; end
        if (!e.r2 && e.t2 == bus.CDB_tag) begin e.r2 = 1'b1; e.d2 = bus.CDB_data; end
        mq[i] = e;
      end
    end
    if (fire) mq.delete(w);
    if (accept) begin
      m1 = !bus.dispatch_rs1_valid && bus.CDB_valid && (bus.CDB_tag == bus.dispatch_rs1_tag);
      m2 = !bus.dispatch_rs2_valid && bus.CDB_valid && (bus.CDB_tag == bus.dispatch_rs2_tag);
      e.r1  = bus.dispatch_rs1_valid || m1;
      e.r2  = bus.dispatch_rs2_valid || m2;
      e.t1  = bus.dispatch_rs1_tag;
      e.t2  = bus.dispatch_rs2_tag;
      e.d1  = bus.dispatch_rs1_valid ? bus.dispatch_rs1_data : (m1 ? bus.CDB_data : '0);
      e.d2  = bus.dispatch_rs2_valid ? bus.dispatch_rs2_data : (m2 ? bus.CDB_data : '0);
      e.opc = bus.dispatch_opcode;
      e.rd  = bus.dispatch_rd_tag;
      e.imm = bus.dispatch_imm;
      mq.push_back(e);
    end
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic set_idle();
    bus.dispatch_en_integer = 1'b0;
    bus.dispatch_opcode     = '0;
    bus.dispatch_rd_tag     = '0;
    bus.dispatch_rs1_data   = '0;
    bus.dispatch_rs1_tag    = '0;
    bus.dispatch_rs1_valid  = 1'b0;
    bus.dispatch_rs2_data   = '0;
    bus.dispatch_rs2_tag    = '0;
    bus.dispatch_rs2_valid  = 1'b0;
    bus.dispatch_imm        = '0;
    bus.CDB_valid           = 1'b0;
    bus.CDB_tag             = '0;
    bus.CDB_data            = '0;
  endtask

  task automatic disp(input logic [OPC_W-1:0] op, input logic [TAG_W-1:0] rd,
                      input logic v1, input logic [TAG_W-1:0] t1, input logic [DATA_W-1:0] d1,
                      input logic v2, input logic [TAG_W-1:0] t2, input logic [DATA_W-1:0] d2,
                      input logic [DATA_W-1:0] imm);
    bus.dispatch_en_integer = 1'b1;
    bus.dispatch_opcode     = op;
    bus.dispatch_rd_tag     = rd;
    bus.dispatch_rs1_valid  = v1;
    bus.dispatch_rs1_tag    = t1;
    bus.dispatch_rs1_data   = d1;
    bus.dispatch_rs2_valid  = v2;
    bus.dispatch_rs2_tag    = t2;
    bus.dispatch_rs2_data   = d2;
    bus.dispatch_imm        = imm;
  endtask

  task automatic cdb(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
    bus.CDB_valid = 1'b1;
    bus.CDB_tag   = tag;
    bus.CDB_data  = data;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    set_idle();
    bus.issue_ready = 1'b0;
    #12;
    check_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    // Ready dispatch issues next cycle and is removed on the handshake.
    bus.issue_ready = 1'b1;
    disp(5'd5, 6'd7, 1'b1, 6'd0, 32'd10, 1'b1, 6'd0, 32'd20, 32'd0);
    step("t2");
    chk("t2_vld", 32'(bus.issue_valid), 32'd1);
    chk("t2_rs1", bus.issue_rs1_data, 32'd10);
    chk("t2_rs2", bus.issue_rs2_data, 32'd20);
    chk("t2_rd",  32'(bus.issue_rd_tag), 32'd7);
    set_idle();
    step("t2_gone");
    chk("t2_removed", 32'(bus.issue_valid), 32'd0);

    // CDB wakeup two cycles after dispatch; a non-matching tag must not wake.
    disp(5'd1, 6'd8, 1'b0, 6'd12, 32'd0, 1'b1, 6'd0, 32'd4, 32'd3);
    step("t3_disp");
    set_idle();
    cdb(6'd13, 32'h1111);
    step("t3_wrong");
    chk("t3_no_wake", 32'(bus.issue_valid), 32'd0);
    cdb(6'd12, 32'hABCD);
    step("t3_wake");
    chk("t3_vld", 32'(bus.issue_valid), 32'd1);
    chk("t3_rs1", bus.issue_rs1_data, 32'hABCD);
    set_idle();
    step("t3_gone");

    // Fill, drop when full, then simultaneous issue + dispatch.
    bus.issue_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      disp(OPC_W'(k + 1), TAG_W'(20 + k), 1'b1, 6'd0, 32'(100 + k), 1'b1, 6'd0, 32'(200 + k), 32'(k));
      step("t4_fill");
    end
    chk("t4_full", 32'(bus.issueque_full_integer), 32'd1);
    disp(5'd9, 6'd30, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd2, 32'd0);
    step("t4_drop");
    bus.issue_ready = 1'b1;
    disp(5'd9, 6'd31, 1'b1, 6'd0, 32'd3, 1'b1, 6'd0, 32'd4, 32'd0);
    step("t4_swap");
    chk("t4_full_keep", 32'(bus.issueque_full_integer), 32'd1);
    chk("t4_head", 32'(bus.issue_rd_tag), 32'd21);
    set_idle();
    step("t4_drain");
    step("t4_drain");
    step("t4_drain");
    chk("t4_last", 32'(bus.issue_rd_tag), 32'd31);
    step("t4_drain");
    chk("t4_empty", 32'(bus.issue_valid), 32'd0);

    // Younger ready op overtakes a waiting one; age order survives the collapse.
    bus.issue_ready = 1'b0;
    disp(5'd2, 6'd40, 1'b0, 6'd3, 32'd0, 1'b1, 6'd0, 32'd6, 32'd0);
    step("t5_d0");
    disp(5'd3, 6'd41, 1'b1, 6'd0, 32'd7, 1'b1, 6'd0, 32'd8, 32'd0);
    step("t5_d1");
    chk("t5_first", 32'(bus.issue_rd_tag), 32'd41);
    set_idle();
    bus.issue_ready = 1'b1;
    step("t5_iss");
    chk("t5_wait", 32'(bus.issue_valid), 32'd0);
    cdb(6'd3, 32'h33);
    step("t5_wake");
    chk("t5_second", 32'(bus.issue_rd_tag), 32'd40);
    chk("t5_rs1", bus.issue_rs1_data, 32'h33);
    set_idle();
    step("t5_gone");

    // Dispatch bypass from a same-cycle CDB broadcast.
    disp(5'd4, 6'd50, 1'b1, 6'd0, 32'd1, 1'b0, 6'd9, 32'd0, 32'd0);
    cdb(6'd9, 32'h55);
    step("t6");
    chk("t6_vld", 32'(bus.issue_valid), 32'd1);
    chk("t6_rs2", bus.issue_rs2_data, 32'h55);
    set_idle();
    step("t6_gone");

    // Asynchronous reset with three entries held.
    bus.issue_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      disp(5'd6, TAG_W'(k + 1), 1'b1, 6'd0, 32'(k), 1'b1, 6'd0, 32'(k), 32'(k));
      step("t1_fill");
    end
    set_idle();
    #2;
    reset = 1'b1;
    mq.delete();
    #1;
    check_outputs("t1_async");
    @(negedge clk);
    reset = 1'b0;
    step("t1_after");
    chk("t1_vld", 32'(bus.issue_valid), 32'd0);

    // Random traffic with a small tag space so wakeups and bypasses are frequent.
    for (int n = 0; n < 400; n++) begin
      bus.issue_ready         = ($urandom_range(9, 0) < 7);
      bus.dispatch_en_integer = ($urandom_range(9, 0) < 6);
      bus.dispatch_opcode     = OPC_W'($urandom);
      bus.dispatch_rd_tag     = TAG_W'($urandom);
      bus.dispatch_rs1_valid  = ($urandom_range(1, 0) == 1);
      bus.dispatch_rs1_tag    = TAG_W'($urandom_range(7, 0));
      bus.dispatch_rs1_data   = $urandom;
      bus.dispatch_rs2_valid  = ($urandom_range(1, 0) == 1);
      bus.dispatch_rs2_tag    = TAG_W'($urandom_range(7, 0));
      bus.dispatch_rs2_data   = $urandom;
      bus.dispatch_imm        = $urandom;
      bus.CDB_valid           = ($urandom_range(9, 0) < 4);
      bus.CDB_tag             = TAG_W'($urandom_range(7, 0));
      bus.CDB_data            = $urandom;
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
